// File: rtl/query_patch_mem_wb_pkg.sv
// Shared constants and types for the query-patch store: default geometry,
// the patch word type and the Wishbone byte-lane expansion helper.
package query_patch_mem_wb_pkg;

   localparam int DATA_WIDTH_DEF = 11;
   localparam int PATCH_SIZE_DEF = 5;
   localparam int ADDR_WIDTH_DEF = 9;
   localparam int DEPTH_DEF      = 512;
   localparam int PW_DEF         = DATA_WIDTH_DEF * PATCH_SIZE_DEF;
   localparam int WB_DW          = 32;

   typedef logic [PW_DEF-1:0] patch_t;

   // Expands the four Wishbone byte selects into a 32-bit bit mask.
   function automatic logic [WB_DW-1:0] sel_to_bits(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/query_patch_wb_if.sv
// Wishbone slave front end: single-cycle ack handshake, address split into
// entry index / word half, and byte-lane mask generation for the patch array.
module query_patch_wb_if
   import query_patch_mem_wb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int PW         = PW_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wb_mode_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [WB_DW-1:0]      wbs_dat_i,
   input  logic [WB_DW-1:0]      wbs_adr_i,
   output logic                  wbs_ack_o,
   output logic [WB_DW-1:0]      wbs_dat_o,
   output logic                  req_wr_o,
   output logic [ADDR_WIDTH-1:0] req_idx_o,
   output logic [PW-1:0]         req_mask_o,
   output logic [PW-1:0]         req_data_o,
   input  logic [PW-1:0]         req_rdata_i
);

   logic             accept;
   logic             hi_sel;
   logic             ack_q, ack_d;
   logic [WB_DW-1:0] dat_q, dat_d;
   logic [63:0]      mask_wide;
   logic [63:0]      data_wide;
   logic [63:0]      rdata_wide;
   logic [WB_DW-1:0] rd_word;
   logic             unused_bits;

   // A new transfer is taken only while no ack is outstanding, so a held
   // strobe restarts one cycle after the ack falls.
   assign accept    = wb_mode_i & wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign hi_sel    = wbs_adr_i[2];
   assign req_idx_o = wbs_adr_i[ADDR_WIDTH+2:3];

   assign mask_wide = hi_sel ? {sel_to_bits(wbs_sel_i), 32'h0}
                             : {32'h0, sel_to_bits(wbs_sel_i)};
   assign data_wide = hi_sel ? {wbs_dat_i, 32'h0} : {32'h0, wbs_dat_i};

   // Bits of the upper word beyond the patch width fall off here.
   assign req_mask_o = mask_wide[PW-1:0];
   assign req_data_o = data_wide[PW-1:0];
   assign req_wr_o   = accept & wbs_we_i;

   assign rdata_wide = 64'(req_rdata_i);
   assign rd_word    = hi_sel ? rdata_wide[63:32] : rdata_wide[31:0];

   assign unused_bits = ^{mask_wide[63:PW], data_wide[63:PW],
                          wbs_adr_i[WB_DW-1:ADDR_WIDTH+3], wbs_adr_i[1:0]};

   always_comb begin
      ack_d = accept;
      dat_d = dat_q;
      if (accept && !wbs_we_i) begin
         dat_d = rd_word;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

endmodule

// File: rtl/query_patch_mem_wb.sv
// Query-patch store: one R/W native port, one read-only search port and a
// Wishbone window that owns write access while wb_mode is set.
module query_patch_mem_wb
   import query_patch_mem_wb_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PATCH_SIZE = PATCH_SIZE_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             csb0,
   input  logic                             web0,
   input  logic [ADDR_WIDTH-1:0]            addr0,
   input  logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
   output logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch0,
   input  logic                             csb1,
   input  logic [ADDR_WIDTH-1:0]            addr1,
   output logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch1,
   input  logic                             wb_mode,
   input  logic                             wbs_stb_i,
   input  logic                             wbs_cyc_i,
   input  logic                             wbs_we_i,
   input  logic [3:0]                       wbs_sel_i,
   input  logic [31:0]                      wbs_dat_i,
   input  logic [31:0]                      wbs_adr_i,
   output logic                             wbs_ack_o,
   output logic [31:0]                      wbs_dat_o
);

   localparam int PW = DATA_WIDTH * PATCH_SIZE;

   logic [PW-1:0]         mem_q [DEPTH];

   logic                  wb_wr;
   logic [ADDR_WIDTH-1:0] wb_idx;
   logic [PW-1:0]         wb_mask;
   logic [PW-1:0]         wb_data;
   logic [PW-1:0]         wb_rdata;

   logic                  p0_wr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic [PW-1:0]         wr_mask;
   logic [PW-1:0]         wr_data;

   logic [PW-1:0]         rd0, rd1;
   logic [PW-1:0]         rpatch0_q, rpatch0_d;
   logic [PW-1:0]         rpatch1_q, rpatch1_d;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
      return 32'(idx) < DEPTH;
   endfunction

   query_patch_wb_if #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PW         (PW)
   ) u_wb_if (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .wb_mode_i   (wb_mode),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_sel_i   (wbs_sel_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_dat_o   (wbs_dat_o),
      .req_wr_o    (wb_wr),
      .req_idx_o   (wb_idx),
      .req_mask_o  (wb_mask),
      .req_data_o  (wb_data),
      .req_rdata_i (wb_rdata)
   );

   // Out-of-range indices read as zero on every port.
   assign rd0      = in_range(addr0)  ? mem_q[addr0]  : '0;
   assign rd1      = in_range(addr1)  ? mem_q[addr1]  : '0;
   assign wb_rdata = in_range(wb_idx) ? mem_q[wb_idx] : '0;

   // wb_mode makes the two writers mutually exclusive, so one write port suffices.
   assign p0_wr = ~csb0 & ~web0 & ~wb_mode;

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = addr0;
      wr_mask = '1;
      wr_data = wpatch0;
      if (wb_wr) begin
         wr_en   = in_range(wb_idx);
         wr_idx  = wb_idx;
         wr_mask = wb_mask;
         wr_data = wb_data;
      end else if (p0_wr) begin
         wr_en = in_range(addr0);
      end
   end

   // Array contents survive reset; reads sample the pre-write value.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   always_comb begin
      rpatch0_d = rpatch0_q;
      rpatch1_d = rpatch1_q;
      if (!csb0 && web0) begin
         rpatch0_d = rd0;
      end
      if (!csb1) begin
         rpatch1_d = rd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpatch0_q <= '0;
         rpatch1_q <= '0;
      end else begin
         rpatch0_q <= rpatch0_d;
         rpatch1_q <= rpatch1_d;
      end
   end

   assign rpatch0 = rpatch0_q;
   assign rpatch1 = rpatch1_q;

endmodule

// File: tb/tb_query_patch_mem_wb.sv
// Bench for query_patch_mem_wb: directed sequences, a Wishbone vector table
// and randomized traffic compared against a cycle-level reference model.
module tb_query_patch_mem_wb;

   localparam int DW    = 11;
   localparam int PS    = 5;
   localparam int AW    = 9;
   localparam int DEPTH = 500;
   localparam int PW    = DW * PS;

   typedef struct {
      logic          we;
      logic [31:0]   adr;
      logic [3:0]    sel;
      logic [31:0]   dat;
      logic [31:0]   exp_word;
      logic          p1chk;
      logic [AW-1:0] p1_addr;
      logic [PW-1:0] exp_p1;
   } wb_vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          csb0, web0, csb1;
   logic [AW-1:0] addr0, addr1;
   logic [PW-1:0] wpatch0, rpatch0, rpatch1;
   logic          wb_mode;
   logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]    wbs_sel_i;
   logic [31:0]   wbs_dat_i, wbs_adr_i;
   logic          wbs_ack_o;
   logic [31:0]   wbs_dat_o;

   // Reference model state
   logic [PW-1:0] mem_m [DEPTH];
   logic [PW-1:0] exp_r0, exp_r1;
   logic          exp_ack;
   logic [31:0]   exp_dat;

   int n_checks = 0;
   int n_errors = 0;

   wb_vec_t vec [13];

   always #5 clk = ~clk;

   query_patch_mem_wb #(
      .DATA_WIDTH (DW),
      .PATCH_SIZE (PS),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .csb0      (csb0),
      .web0      (web0),
      .addr0     (addr0),
      .wpatch0   (wpatch0),
      .rpatch0   (rpatch0),
      .csb1      (csb1),
      .addr1     (addr1),
      .rpatch1   (rpatch1),
      .wb_mode   (wb_mode),
      .wbs_stb_i (wbs_stb_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] m_rd(input logic [AW-1:0] a);
      if (int'(a) >= DEPTH) return '0;
      return mem_m[a];
   endfunction

   // One clock of the behavioural model, evaluated on the values the DUT samples.
   task automatic model_step();
      logic          acc;
      logic [AW-1:0] idx;
      int            base;
      logic [63:0]   e;
      if (!rst_n) begin
         exp_r0  = '0;
         exp_r1  = '0;
         exp_ack = 1'b0;
         exp_dat = '0;
         return;
      end
      idx  = wbs_adr_i[AW+2:3];
      base = wbs_adr_i[2] ? 32 : 0;
      acc  = wb_mode && wbs_cyc_i && wbs_stb_i && !exp_ack;
      if (!csb0 && web0) exp_r0 = m_rd(addr0);
      if (!csb1) exp_r1 = m_rd(addr1);
      if (acc && !wbs_we_i) begin
         e       = 64'(m_rd(idx));
         exp_dat = e[base +: 32];
      end
      if (!csb0 && !web0 && !wb_mode && int'(addr0) < DEPTH) mem_m[addr0] = wpatch0;
      if (acc && wbs_we_i && int'(idx) < DEPTH) begin
         e = 64'(mem_m[idx]);
         for (int b = 0; b < 4; b++)
            if (wbs_sel_i[b]) e[base + 8*b +: 8] = wbs_dat_i[8*b +: 8];
         mem_m[idx] = e[PW-1:0];
      end
      exp_ack = acc;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      csb0 = 1'b1; web0 = 1'b1; addr0 = '0; wpatch0 = '0;
      csb1 = 1'b1; addr1 = '0;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = '0; wbs_dat_i = '0; wbs_adr_i = '0;
   endtask

   task automatic p0_write(input logic [AW-1:0] a, input logic [PW-1:0] d);
      csb0 = 1'b0; web0 = 1'b0; addr0 = a; wpatch0 = d;
      tick();
      csb0 = 1'b1; web0 = 1'b1;
   endtask

   task automatic wb_xfer(input wb_vec_t v, input string name);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
      wbs_adr_i = v.adr; wbs_sel_i = v.sel; wbs_dat_i = v.dat;
      tick();
      check({name, ".ack"}, 64'(wbs_ack_o), 64'(1));
      if (!v.we) check({name, ".rdata"}, 64'(wbs_dat_o), 64'(v.exp_word));
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      tick();
      check({name, ".ack_drop"}, 64'(wbs_ack_o), 64'(0));
      if (v.p1chk) begin
         csb1 = 1'b0; addr1 = v.p1_addr;
         tick();
         check({name, ".p1"}, 64'(rpatch1), 64'(v.exp_p1));
         csb1 = 1'b1;
      end
   endtask

   function automatic logic [AW-1:0] pick_addr();
      int k = int'($urandom_range(0, 37));
      return (k < 16) ? AW'(k) : AW'(490 + k - 16);
   endfunction

   initial begin
      logic    exp_seq [4];
      wb_vec_t rd60;
      logic [31:0] a;

      //          we    adr            sel   dat            exp_word       p1   p1a      exp_p1
      vec[0]  = '{1'b1, 32'h0000_0058, 4'hF, 32'h0000_0002, 32'h0,         1'b1, 9'd11,  55'h2};
      vec[1]  = '{1'b1, 32'h0000_005C, 4'h1, 32'h007F_FFFF, 32'h0,         1'b1, 9'd11,  55'hFF00000002};
      vec[2]  = '{1'b0, 32'h0000_005C, 4'hF, 32'h0,         32'h0000_00FF, 1'b0, 9'd0,   55'h0};
      vec[3]  = '{1'b0, 32'h0000_0058, 4'hF, 32'h0,         32'h0000_0002, 1'b0, 9'd0,   55'h0};
      vec[4]  = '{1'b1, 32'h0000_0060, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0, 9'd0,   55'h0};
      vec[5]  = '{1'b1, 32'h0000_0060, 4'h5, 32'h1234_5678, 32'h0,         1'b1, 9'd12,  55'hDE34BE78};
      vec[6]  = '{1'b0, 32'hABC0_0063, 4'hF, 32'h0,         32'hDE34_BE78, 1'b0, 9'd0,   55'h0};
      vec[7]  = '{1'b1, 32'h0000_0064, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 9'd12,  55'h7FFFFFDE34BE78};
      vec[8]  = '{1'b0, 32'h0000_0064, 4'hF, 32'h0,         32'h007F_FFFF, 1'b0, 9'd0,   55'h0};
      vec[9]  = '{1'b1, 32'h0000_0FC8, 4'hF, 32'hAAAA_AAAA, 32'h0,         1'b1, 9'd505, 55'h0};
      vec[10] = '{1'b0, 32'h0000_0FC8, 4'hF, 32'h0,         32'h0,         1'b0, 9'd0,   55'h0};
      vec[11] = '{1'b1, 32'h0000_0064, 4'h8, 32'h0,         32'h0,         1'b1, 9'd12,  55'h7FFFFFDE34BE78};
      vec[12] = '{1'b1, 32'h0000_0064, 4'h4, 32'h0,         32'h0,         1'b1, 9'd12,  55'h00FFFFDE34BE78};

      // Reset
      idle();
      wb_mode = 1'b0;
      rst_n   = 1'b0;
      exp_r0 = '0; exp_r1 = '0; exp_ack = 1'b0; exp_dat = '0;
      csb1 = 1'b0;
      tick(); tick(); tick();
      check("reset.rpatch0", 64'(rpatch0), 64'(0));
      check("reset.rpatch1", 64'(rpatch1), 64'(0));
      check("reset.ack", 64'(wbs_ack_o), 64'(0));
      check("reset.wbdat", 64'(wbs_dat_o), 64'(0));
      csb1  = 1'b1;
      rst_n = 1'b1;

      // Port 0 write then read
      p0_write(9'd0, 55'd1);
      check("p0.hold_on_write", 64'(rpatch0), 64'(0));
      csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd0;
      tick();
      check("p0.read", 64'(rpatch0), 64'(1));
      csb0 = 1'b1;

      // Known contents for the rest of the run
      for (int i = 1; i < 16; i++) p0_write(AW'(i), (i == 3) ? 55'd4 : 55'd0);
      for (int i = 490; i < DEPTH; i++) p0_write(AW'(i), PW'(i * 12345));

      // Port 0 write blocked while Wishbone owns writes
      wb_mode = 1'b1;
      p0_write(9'd0, 55'd9);
      csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd0;
      tick();
      check("p0.blocked_write", 64'(rpatch0), 64'(1));
      csb0 = 1'b1;

      for (int i = 0; i < 13; i++) wb_xfer(vec[i], $sformatf("vec%0d", i));

      rd60 = '{1'b0, 32'h0000_0060, 4'hF, 32'h0, 32'hDE34_BE78, 1'b0, 9'd0, 55'h0};
      wb_xfer(rd60, "rd60");

      // Wishbone ignored with wb_mode=0
      wb_mode = 1'b0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h58; wbs_sel_i = 4'hF;
      wbs_dat_i = 32'h0000_0BAD;
      for (int k = 0; k < 5; k++) begin
         wbs_we_i = k[0];
         tick();
         check($sformatf("nomode.ack%0d", k), 64'(wbs_ack_o), 64'(0));
         check($sformatf("nomode.dat%0d", k), 64'(wbs_dat_o), 64'(32'hDE34_BE78));
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      csb1 = 1'b0; addr1 = 9'd11;
      tick();
      check("nomode.entry11", 64'(rpatch1), 64'(55'hFF00000002));
      csb1 = 1'b1;

      // Held strobe: ack pulses every other cycle
      wb_mode = 1'b1;
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h58;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("held.ack%0d", k), 64'(wbs_ack_o), 64'(exp_seq[k]));
      end
      check("held.dat", 64'(wbs_dat_o), 64'(2));

      // wb_mode drops while the ack is out
      tick();
      check("modefall.ack_hi", 64'(wbs_ack_o), 64'(1));
      wb_mode = 1'b0;
      tick();
      check("modefall.ack_lo", 64'(wbs_ack_o), 64'(0));
      tick();
      check("modefall.ack_stays", 64'(wbs_ack_o), 64'(0));
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

      // Same-cycle port 0 write and port 1 read
      csb0 = 1'b0; web0 = 1'b0; addr0 = 9'd3; wpatch0 = 55'd7;
      csb1 = 1'b0; addr1 = 9'd3;
      tick();
      check("rbw.p1_old", 64'(rpatch1), 64'(4));
      csb0 = 1'b1; web0 = 1'b1;
      tick();
      check("rbw.p1_new", 64'(rpatch1), 64'(7));

      // Same-cycle Wishbone write and port 1 read
      wb_mode = 1'b1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = 32'h58; wbs_sel_i = 4'hF; wbs_dat_i = 32'h55;
      addr1 = 9'd11;
      tick();
      check("wbrbw.ack", 64'(wbs_ack_o), 64'(1));
      check("wbrbw.p1_old", 64'(rpatch1), 64'(55'hFF00000002));
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      tick();
      check("wbrbw.p1_new", 64'(rpatch1), 64'(55'hFF00000055));
      idle();

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         if (c % 16 == 0) wb_mode = 1'($urandom_range(0, 1));
         csb0    = 1'($urandom_range(0, 1));
         web0    = 1'($urandom_range(0, 1));
         addr0   = pick_addr();
         wpatch0 = PW'({$urandom(), $urandom()});
         csb1    = 1'($urandom_range(0, 1));
         addr1   = pick_addr();
         wbs_stb_i = 1'($urandom_range(0, 1));
         wbs_cyc_i = ($urandom_range(0, 3) != 0);
         wbs_we_i  = 1'($urandom_range(0, 1));
         wbs_sel_i = 4'($urandom());
         wbs_dat_i = $urandom();
         a = $urandom();
         a[AW+2:3] = pick_addr();
         wbs_adr_i = a;
         tick();
         check($sformatf("rnd%0d.rpatch0", c), 64'(rpatch0), 64'(exp_r0));
         check($sformatf("rnd%0d.rpatch1", c), 64'(rpatch1), 64'(exp_r1));
         check($sformatf("rnd%0d.ack", c), 64'(wbs_ack_o), 64'(exp_ack));
         check($sformatf("rnd%0d.wbdat", c), 64'(wbs_dat_o), 64'(exp_dat));
      end

      // Asynchronous reset clears outputs without a clock edge
      idle();
      wb_mode = 1'b1;
      csb0 = 1'b0; addr0 = 9'd495; csb1 = 1'b0; addr1 = 9'd496;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h60;
      tick();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      check("areset.rpatch0", 64'(rpatch0), 64'(0));
      check("areset.rpatch1", 64'(rpatch1), 64'(0));
      check("areset.ack", 64'(wbs_ack_o), 64'(0));
      check("areset.wbdat", 64'(wbs_dat_o), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/query_patch_mem_wb.md
Name: query_patch_mem_wb

Overview:
- Query-patch storage for the ANN accelerator: DEPTH entries, each one patch of PATCH_SIZE signed/unsigned DATA_WIDTH-bit elements.
- Native port 0 reads and writes entries; port 1 is read-only and used by the search datapath.
- A Wishbone slave lets the management SoC load or inspect patches when wb_mode=1.
- All logic runs on one clock.

Parameters:
- DATA_WIDTH, 11: bits per patch element
- PATCH_SIZE, 5: elements per patch; PW = DATA_WIDTH*PATCH_SIZE (55)
- ADDR_WIDTH, 9: entry address width
- DEPTH, 512: number of entries (≤ 2^ADDR_WIDTH)

Ports:
- clk  in  1  sole clock; Wishbone also runs on clk
- rst_n  in  1  asynchronous active-low reset
- csb0  in  1  port 0 chip select, active low
- web0  in  1  port 0 write enable, active low (0 = write)
- addr0  in  ADDR_WIDTH  port 0 entry address
- wpatch0  in  PW  port 0 write data
- rpatch0  out  PW  port 0 read data
- csb1  in  1  port 1 chip select, active low
- addr1  in  ADDR_WIDTH  port 1 entry address
- rpatch1  out  PW  port 1 read data
- wb_mode  in  1  1 = Wishbone owns write access; port 0 writes blocked
- wbs_stb_i, wbs_cyc_i  in  1 each  Wishbone strobe / cycle
- wbs_we_i  in  1  Wishbone write
- wbs_sel_i  in  4  byte enables
- wbs_dat_i  in  32  Wishbone write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  Wishbone acknowledge
- wbs_dat_o  out  32  Wishbone read data

Behaviour:
- Reset (rst_n=0, async): rpatch0, rpatch1, wbs_dat_o = 0; wbs_ack_o = 0. Memory array is not cleared.
- Port 0, rising clk, csb0=0, web0=0, wb_mode=0: mem[addr0] <= wpatch0. rpatch0 holds its value.
- Port 0 read, csb0=0, web0=1: rpatch0 <= mem[addr0]. Latency is 1 cycle. Reads are allowed in either wb_mode.
- Port 0 write attempted while wb_mode=1: ignored; memory is unchanged.
- csb0=1: port 0 is idle and rpatch0 holds. The same hold rule applies to port 1 with csb1=1.
- Port 1, csb1=0: rpatch1 <= mem[addr1] with 1-cycle latency, independent of wb_mode.
- Read-before-write: a same-cycle read of an address being written, from any port, returns the old data.
- Wishbone address map:
  - entry index = wbs_adr_i[ADDR_WIDTH+2:3]
  - wbs_adr_i[2] = 0 selects patch bits [31:0]
  - wbs_adr_i[2] = 1 selects bits [PW-1:32], zero-extended on read; write bits above PW-1 are dropped
  - wbs_adr_i[1:0] and bits above ADDR_WIDTH+2 are ignored
- Wishbone transfer, accepted when wb_mode=1 & wbs_cyc_i & wbs_stb_i & !wbs_ack_o:
  - Same edge: the write is performed, or wbs_dat_o is loaded with the selected word.
  - wbs_ack_o=1 for exactly one cycle, then 0.
  - Master drops stb after ack; a held stb starts a new transfer the cycle after ack falls.
- Wishbone writes honour wbs_sel_i per byte. Unselected bits of the entry are preserved.
- wb_mode=0: Wishbone requests are never acked and wbs_dat_o holds.
- wb_mode falling during an outstanding ack: the ack still completes its single cycle.
- Address with index ≥ DEPTH, any port: writes ignored, reads return 0.
- Wishbone write and port 1 read of the same entry in the same cycle: port 1 returns old data.

Decomposition:
- Shared package: default DATA_WIDTH/PATCH_SIZE/ADDR_WIDTH constants, PW derivation, patch_t typedef (PW bits).
- One natural sub-module, query_patch_wb_if. It does the Wishbone handshake, address split, and byte-mask generation. It presents a single internal write/read request (index, 55-bit mask, 55-bit data) to the array.
- The top level holds the array, port muxing, and the wb_mode gating.

Test Plan:
- Reset, then port 0 write with addr0=0, wpatch0=55'd1, csb0=0, web0=0. Next cycle web0=1 -> rpatch0=55'd1 one cycle later. rpatch0/rpatch1 read 0 during reset.
- wb_mode=1, then port 0 write of 55'd9 to addr 0 -> subsequent read of addr 0 still returns 55'd1.
- wb_mode=1, Wishbone write adr=0x58 (entry 11, low word), dat=0x00000002, sel=0xF -> ack one cycle. csb1=0, addr1=11 -> rpatch1=55'd2.
- Wishbone write adr=0x5C (entry 11, high word), dat=0x007FFFFF, sel=0x1 -> entry 11 = {15'b0, 8'hFF, 32'h2}. Wishbone read of 0x5C returns 0x000000FF with ack.
- wb_mode=0 with stb=cyc=1 for 5 cycles -> wbs_ack_o stays 0.
- Same-cycle port 0 write of 55'd7 and port 1 read at addr 3 (old value 55'd4) -> rpatch1=4; the next read returns 7.
